// File: rtl/ts_rx_analyzer.sv
// ts_rx_analyzer: per-lane TS1/TS2 consecutive-match detector with decoded fields
//   clk, rst (async, active-high)
//   ts_i[127:0], ts_i_vld, clr
//   ts1_det, ts2_det, match_cnt[3:0], link_num, lane_num, rate, ctrl [7:0], bad_ts
module ts_rx_analyzer #(
  parameter int MATCH_CNT = 8,
  parameter int GAP_MAX   = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] ts_i,
  input  logic         ts_i_vld,
  input  logic         clr,
  output logic         ts1_det,
  output logic         ts2_det,
  output logic [3:0]   match_cnt,
  output logic [7:0]   link_num,
  output logic [7:0]   lane_num,
  output logic [7:0]   rate,
  output logic [7:0]   ctrl,
  output logic         bad_ts
);
  localparam logic [3:0]  MC  = 4'(MATCH_CNT);
  localparam logic [15:0] GAP = 16'(GAP_MAX);
  logic [127:0] st_q, st_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [15:0]  gap_q, gap_d;
  logic         ts1_q, ts2_q, bad_q, ts1_d, ts2_d, bad_d;
  logic         wf, same, take, tmo;
  always_comb begin
    wf    = ts_i[7:0] == 8'hBC &&
            (ts_i[127:48] == {10{8'h4A}} || ts_i[127:48] == {10{8'h45}});
    same  = ts_i == st_q && cnt_q != 4'd0;
    take  = ts_i_vld && !clr;
    tmo   = gap_q >= GAP;
    st_d  = take && wf && !same ? ts_i : st_q;
    cnt_d = clr      ? 4'd0 :
            ts_i_vld ? (!wf ? 4'd0 : same ? (cnt_q == 4'd15 ? cnt_q : cnt_q + 4'd1) : 4'd1) :
            tmo      ? 4'd0 : cnt_q;
    gap_d = clr || ts_i_vld ? 16'd0 :
            cnt_q != 4'd0 && gap_q != 16'hFFFF ? gap_q + 16'd1 : gap_q;
    // stored TS is always zero or well-formed, so byte 6 alone identifies its type
    ts1_d = cnt_d >= MC && st_d[55:48] == 8'h4A;
    ts2_d = cnt_d >= MC && st_d[55:48] == 8'h45;
    bad_d = take && !wf;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= '0;
      cnt_q <= '0;
      gap_q <= '0;
      ts1_q <= 1'b0;
      ts2_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      ts1_q <= ts1_d;
      ts2_q <= ts2_d;
      bad_q <= bad_d;
    end
  end
  assign ts1_det   = ts1_q;
  assign ts2_det   = ts2_q;
  assign bad_ts    = bad_q;
  assign match_cnt = cnt_q;
  assign link_num  = st_q[15:8];
  assign lane_num  = st_q[23:16];
  assign rate      = st_q[39:32];
  assign ctrl      = st_q[47:40];
endmodule
